// File: rtl/ins_prefetch_queue.sv
// Fetch-side instruction queue: cache words buffered in a DEPTH-entry ring, one registered instruction per cycle to decode.
// Latency 1 cycle (bypass when empty); decode backpressure via STALL_ENABLE, cache throttled by FETCH_ENABLE.
module ins_prefetch_queue #(
   parameter int          DEPTH   = 4,
   parameter int          PTR_W   = 2,
   parameter logic [31:0] NOP_INS = 32'h0000_0013
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             INS_CACHE_READY,
   input  logic [31:0]      INS_CACHE_DATA,
   input  logic [31:0]      INS_CACHE_PC,
   input  logic             STALL_ENABLE,
   input  logic             FLUSH,
   output logic [31:0]      INSTRUCTION,
   output logic [31:0]      PC_OUT,
   output logic             INS_VALID,
   output logic             FETCH_ENABLE,
   output logic [PTR_W:0]   COUNT,
   output logic             OVERFLOW
);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);

   logic [31:0]    ins_mem_q [DEPTH];
   logic [31:0]    ins_mem_d [DEPTH];
   logic [31:0]    pc_mem_q  [DEPTH];
   logic [31:0]    pc_mem_d  [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] count_q, count_d;
   logic [31:0]    ins_q, ins_d, pc_q, pc_d;
   logic           vld_q, vld_d, ovf_q, ovf_d;
   logic           advance, pop, bypass, push_req, push;

   always_comb begin
      advance  = STALL_ENABLE && !FLUSH;
      pop      = advance && (count_q != '0);
      bypass   = advance && (count_q == '0) && INS_CACHE_READY;
      push_req = INS_CACHE_READY && !FLUSH && !bypass;
      // A pop in the same cycle frees the slot, so a full queue still accepts
      push     = push_req && ((count_q != CNT_FULL) || pop);

      ins_mem_d = ins_mem_q;
      pc_mem_d  = pc_mem_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      ins_d     = ins_q;
      pc_d      = pc_q;
      vld_d     = vld_q;
      ovf_d     = ovf_q;

      if (FLUSH) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ins_d    = NOP_INS;
         vld_d    = 1'b0;
      end else begin
         if (advance) begin
            if (pop) begin
               ins_d    = ins_mem_q[rd_ptr_q];
               pc_d     = pc_mem_q[rd_ptr_q];
               vld_d    = 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
            end else if (bypass) begin
               ins_d = INS_CACHE_DATA;
               pc_d  = INS_CACHE_PC;
               vld_d = 1'b1;
            end else begin
               ins_d = NOP_INS;
               vld_d = 1'b0;
            end
         end
         if (push) begin
            ins_mem_d[wr_ptr_q] = INS_CACHE_DATA;
            pc_mem_d[wr_ptr_q]  = INS_CACHE_PC;
            wr_ptr_d            = wr_ptr_q + 1'b1;
         end
         if (push_req && !push) begin
            ovf_d = 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            ins_mem_q[i] <= '0;
            pc_mem_q[i]  <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ins_q    <= NOP_INS;
         pc_q     <= '0;
         vld_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         ins_mem_q <= ins_mem_d;
         pc_mem_q  <= pc_mem_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ins_q     <= ins_d;
         pc_q      <= pc_d;
         vld_q     <= vld_d;
         ovf_q     <= ovf_d;
      end
   end

   // One slot kept spare for a response already in flight from the cache
   assign FETCH_ENABLE = (count_q < (CNT_FULL - CNT_ONE));
   assign INSTRUCTION  = ins_q;
   assign PC_OUT       = pc_q;
   assign INS_VALID    = vld_q;
   assign COUNT        = count_q;
   assign OVERFLOW     = ovf_q;
endmodule
